// File: rtl/sample_stream_arb_pkg.sv
// Shared types, constants and the round-robin search function for the sample stream arbiter.
// rr_next is sized for the largest supported requester count; callers zero-extend narrower request vectors.
package sample_stream_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int STAT_W     = 16;
  localparam int MAX_REQ    = 8;
  localparam int MAX_IDX_W  = $clog2(MAX_REQ);

  // First set bit strictly after ptr, wrapping at n; returns ptr when req is empty.
  function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int idx;
    rr_next = ptr;
    // Walk from the farthest candidate to the nearest so the nearest one wins.
    for (int k = MAX_REQ; k > 0; k--) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_IDX_W-1:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/sample_rr_pick.sv
// Combinational round-robin picker: zero latency, no flow control; o_found is the OR of all requests.
module sample_rr_pick
  import sample_stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_index
);

  logic [MAX_REQ-1:0] w_req_ext;

  assign w_req_ext = MAX_REQ'(i_req);
  assign o_found   = |i_req;
  assign o_index   = IDX_W'(rr_next(w_req_ext, int'(i_ptr), NUM_REQ));

endmodule

// File: rtl/sample_stream_arbiter.sv
// Round-robin, packet-locked arbiter onto one valid/ready stream; 1-cycle arbitration, combinational data path,
// out_ready passes straight to the owner. Stall watchdog frees idle owners. SAMPLE_STREAM_ARB_STATS_EN adds beat_count.
module sample_stream_arbiter
  import sample_stream_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int STALL_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        stall_err
`ifdef SAMPLE_STREAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]   beat_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(STALL_CYCLES);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   w_grant_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [WD_W-1:0]    r_wd_cnt;
  logic [WD_W-1:0]    w_wd_nxt;
  logic               r_stall_err;
  logic               w_stall_nxt;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [DATA_W-1:0]  w_beats [NUM_REQ];
  logic               w_lock;
  logic               w_owner_vld;
  logic               w_owner_last;
  logic               w_xfer;

  sample_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_index (w_pick)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_beats[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  assign w_lock       = (r_state == ARB_LOCK);
  assign w_owner_vld  = req_valid[r_grant];
  assign w_owner_last = req_last[r_grant];
  assign w_xfer       = out_valid & out_ready;

  assign out_valid = w_lock & w_owner_vld;
  assign out_data  = w_beats[r_grant];
  assign grant_id  = r_grant;
  assign busy      = w_lock;
  assign stall_err = r_stall_err;

  always_comb begin
    req_ready = '0;
    if (w_lock) req_ready[r_grant] = out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A transfer needs owner valid high, so a stall expiry can never coincide with a last beat;
  // the release branch is still checked first so that ordering stays explicit.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_wd_nxt    = r_wd_cnt;
    w_stall_nxt = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_nxt = ARB_LOCK;
          w_grant_nxt = w_pick;
          w_ptr_nxt   = w_pick;
          w_wd_nxt    = '0;
        end
      end
      ARB_LOCK: begin
        if (w_xfer && w_owner_last) begin
          w_state_nxt = ARB_IDLE;
        end else if (w_owner_vld) begin
          w_wd_nxt = '0;
        end else if (r_wd_cnt == WD_W'(STALL_CYCLES - 1)) begin
          w_state_nxt = ARB_IDLE;
          w_stall_nxt = 1'b1;
        end else begin
          w_wd_nxt = r_wd_cnt + WD_W'(1);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= '0;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_wd_cnt    <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_wd_cnt    <= w_wd_nxt;
      r_stall_err <= w_stall_nxt;
    end
  end

`ifdef SAMPLE_STREAM_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [STAT_W-1:0] r_beat_cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_beat_cnt <= '0;
      end else if (w_xfer && (r_grant == IDX_W'(gi)) && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + STAT_W'(1);
      end
    end
    assign beat_count[gi*STAT_W +: STAT_W] = r_beat_cnt;
  end
`endif

endmodule

// File: tb/tb_sample_stream_arbiter.sv
// Directed bench for sample_stream_arbiter at default parameters (4 requesters, 8-bit beats, 16-cycle watchdog).
module tb_sample_stream_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        stall_err;
`ifdef SAMPLE_STREAM_ARB_STATS_EN
  logic [63:0] beat_count;
`endif

  int checks;
  int failures;

  sample_stream_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .stall_err (stall_err)
`ifdef SAMPLE_STREAM_ARB_STATS_EN
    ,
    .beat_count(beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic [31:0] dat;
    logic        ordy;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [3:0]  e_rr;
    logic        e_st;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got_gid[$];
    int good;
    int stall_at;
    logic hs;
    checks   = 0;
    failures = 0;

    //            rv       rl       dat           ordy busy gid ov  od     rr       st
    vt[0]  = '{4'b0001, 4'b0000, 32'h00000011, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vt[1]  = '{4'b0001, 4'b0000, 32'h00000011, 1'b1, 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001, 1'b0};
    vt[2]  = '{4'b0001, 4'b0000, 32'h00000022, 1'b1, 1'b1, 2'd0, 1'b1, 8'h22, 4'b0001, 1'b0};
    vt[3]  = '{4'b0001, 4'b0001, 32'h00000033, 1'b1, 1'b1, 2'd0, 1'b1, 8'h33, 4'b0001, 1'b0};
    vt[4]  = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vt[5]  = '{4'b1010, 4'b1010, 32'h43004100, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vt[6]  = '{4'b1010, 4'b1010, 32'h43004100, 1'b1, 1'b1, 2'd1, 1'b1, 8'h41, 4'b0010, 1'b0};
    vt[7]  = '{4'b1000, 4'b1000, 32'h43000000, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vt[8]  = '{4'b1000, 4'b1000, 32'h43000000, 1'b1, 1'b1, 2'd3, 1'b1, 8'h43, 4'b1000, 1'b0};
    vt[9]  = '{4'b0010, 4'b0010, 32'h00005100, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vt[10] = '{4'b0010, 4'b0010, 32'h00005100, 1'b1, 1'b1, 2'd1, 1'b1, 8'h51, 4'b0010, 1'b0};
    vt[11] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};

    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_outputs", {busy, grant_id, out_valid, req_ready, stall_err}, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Packet from requester 0, then 1 and 3 together, then a solo beat from 1.
    for (int i = 0; i < 12; i++) begin
      req_valid = vt[i].rv; req_last = vt[i].rl; req_data = vt[i].dat; out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {busy, out_valid, req_ready, stall_err},
          {vt[i].e_busy, vt[i].e_ov, vt[i].e_rr, vt[i].e_st});
      if (vt[i].e_busy) chk($sformatf("vec%0d_gid", i), 32'(grant_id), 32'(vt[i].e_gid));
      if (vt[i].e_ov)   chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].e_od));
      next_cycle();
    end

    // All four request single-beat packets continuously; pointer sits at 1.
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'hC3C2C1C0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) begin
        got_gid.push_back(int'(grant_id));
        chk($sformatf("rr_data%0d", i), 32'(out_data), 32'hC0 + 32'(grant_id));
      end
      next_cycle();
    end
    chk("rr_count", 32'(got_gid.size()), 32'd4);
    if (got_gid.size() == 4) begin
      chk("rr_order0", 32'(got_gid[0]), 32'd2);
      chk("rr_order1", 32'(got_gid[1]), 32'd3);
      chk("rr_order2", 32'(got_gid[2]), 32'd0);
      chk("rr_order3", 32'(got_gid[3]), 32'd1);
    end
    req_valid = '0; req_last = '0;
    next_cycle();

    // Owner 2 held off by out_ready for 40 cycles: backpressure, not a stall.
    req_valid = 4'b0100; req_last = 4'b0100; req_data = 32'h00A50000; out_ready = 1'b0;
    next_cycle();
    good = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && grant_id == 2'd2 && out_valid && out_data == 8'hA5 && !stall_err && req_ready == 4'b0000)
        good++;
      next_cycle();
    end
    chk("bp_hold_cycles", 32'(good), 32'd40);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {out_valid, out_data, req_ready}, {1'b1, 8'hA5, 4'b0100});
    next_cycle();
    req_valid = '0; req_last = '0;
    @(negedge clk);
    chk("bp_done", {busy, stall_err}, 2'b00);
    next_cycle();

    // Owner 1 goes quiet mid-packet; requester 2 waits.
    req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h00000000 | (32'h61 << 8);
    next_cycle();
    @(negedge clk);
    chk("stall_owner", {busy, grant_id, out_valid}, {1'b1, 2'd1, 1'b1});
    next_cycle();
    req_valid = 4'b0100; req_last = 4'b0100; req_data = 32'h00720000;
    stall_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall_err) begin
        stall_at = i;
        chk("stall_busy_low", 32'(busy), 32'd0);
        next_cycle();
        break;
      end
      next_cycle();
    end
    chk("stall_latency", 32'(stall_at), 32'd16);
    @(negedge clk);
    chk("stall_pulse_next", {stall_err, busy, grant_id, out_data}, {1'b0, 1'b1, 2'd2, 8'h72});
    next_cycle();
    req_valid = '0; req_last = '0;
    next_cycle();

    // Reset during the second beat of a requester-3 packet.
    req_valid = 4'b1000; req_last = 4'b0000; req_data = 32'h81000000;
    next_cycle();
    @(negedge clk);
    chk("rst_pkt_owner", {busy, grant_id}, {1'b1, 2'd3});
    next_cycle();
    req_data = 32'h82000000; rst = 1'b1;
    next_cycle();
    rst = 1'b0; req_valid = 4'b1001; req_last = 4'b0001; req_data = 32'h82000091;
    @(negedge clk);
    chk("rst_mid_outputs", {busy, out_valid, req_ready, stall_err}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rst_first_grant", {busy, grant_id, out_data}, {1'b1, 2'd0, 8'h91});
    next_cycle();
    req_valid = '0; req_last = '0;
    next_cycle();

`ifdef SAMPLE_STREAM_ARB_STATS_EN
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 4; b++) begin
        req_valid = 4'b1000; req_last = {(b == 3), 3'b000}; req_data = 32'(p * 4 + b) << 24;
        hs = 1'b0;
        for (int t = 0; t < 10 && !hs; t++) begin
          @(negedge clk);
          hs = out_valid && req_ready[3];
          next_cycle();
        end
        if (!hs) chk("stats_handshake_timeout", 32'd0, 32'd1);
      end
    end
    req_valid = '0; req_last = '0;
    next_cycle();
    @(negedge clk);
    chk("stats_cnt3", 32'(beat_count[63:48]), 32'd20);
    chk("stats_others", 32'(beat_count[47:0] != 48'h0), 32'd0);
    next_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
